// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and helpers for the nibble-serial adder.
// Optional overflow output is enabled by NIBBLE_SERIAL_ADDER_OVF_EN.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the nibble counter; never narrower than one bit.
    function automatic int cnt_width(input int width);
        int n;
        n = width / NIBBLE_W;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nibble_add_slice.sv
// Combinational 4-bit gate-level ripple-carry slice.
// The bit-3 carry-in port exists only with NIBBLE_SERIAL_ADDER_OVF_EN.
module nibble_add_slice
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    output logic                c3,
`endif
    output logic                co
);

    logic [NIBBLE_W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[NIBBLE_W];
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    assign c3 = c[NIBBLE_W-1];
`endif

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder feeding one nibble per clock through nibble_add_slice.
// Optional two's-complement overflow output enabled by NIBBLE_SERIAL_ADDER_OVF_EN.
//
// state | meaning
// IDLE  | ready for operands
// RUN   | one slice add per cycle, LSB nibble first
// DONE  | result held until out_ready
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 8");
    end

    state_t              state, nstate;
    logic [CNT_W-1:0]    cnt;
    logic [WIDTH-1:0]    a_sh, b_sh;
    logic                carry;
    logic [NIBBLE_W-1:0] s_nib;
    logic                s_co;
    logic                last;

    assign last = (cnt == LAST);

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic s_c3;
`endif

    nibble_add_slice u_slice (
        .a  (a_sh[NIBBLE_W-1:0]),
        .b  (b_sh[NIBBLE_W-1:0]),
        .ci (carry),
        .s  (s_nib),
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        .c3 (s_c3),
`endif
        .co (s_co)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (in_valid) nstate = RUN;
            RUN:     if (last)     nstate = DONE;
            DONE:    if (out_ready) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // Datapath: sum fills from the top so the first nibble ends up at bit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    sum   <= {s_nib, sum[WIDTH-1:NIBBLE_W]};
                    a_sh  <= a_sh >> NIBBLE_W;
                    b_sh  <= b_sh >> NIBBLE_W;
                    carry <= s_co;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        cout <= s_co;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                        ovf  <= s_c3 ^ s_co;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder (WIDTH=16).
// Overflow checks are included when NIBBLE_SERIAL_ADDER_OVF_EN is defined.
module tb_nibble_serial_adder;

    localparam int WIDTH   = 16;
    localparam int NIBBLES = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One operation: accept, count latency, check result, then release.
    task automatic do_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic vcin, input logic [15:0] esum, input logic ecout,
                         input logic eovf);
        int lat;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        a = va; b = vb; cin = vcin; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(NIBBLES));
        check({tag, "_sum"}, 32'(sum), 32'(esum));
        check({tag, "_cout"}, 32'(cout), 32'(ecout));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(eovf));
`else
        if (eovf) begin end
`endif
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_release_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_release_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        step();
        step();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);

        do_op("basic",  16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        do_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("cin",    16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        do_op("zero",   16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        do_op("allone", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);

        // Backpressure: hold result in DONE while new operands are offered.
        a = 16'h1234; b = 16'h4321; cin = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < NIBBLES; i++) step();
        check("bp_valid_rise", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            a = 16'hAAAA; b = 16'h5555; cin = 1'b1; in_valid = 1'b1;
            step();
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_sum", 32'(sum), 32'h5555);
            check("bp_cout", 32'(cout), 32'd0);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_busy", 32'(busy), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);

        // Reset during the second RUN cycle discards the operation.
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("mid_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_sum", 32'(sum), 32'd0);
        check("mid_rst_cout", 32'(cout), 32'd0);
        step();
        check("mid_rst_no_result", 32'(out_valid), 32'd0);
        do_op("after_rst", 16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0);

        do_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        do_op("ovf_none", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle wide adder: adds two WIDTH-bit operands plus carry-in one 4-bit nibble per clock, LSB nibble first, through a single combinational 4-bit ripple-carry slice.
- Sits upstream of the 4-bit adder slice: sequences operand nibbles into it, registers its carry-out back into its carry-in, and collects its sum nibbles into a WIDTH-bit result.
- Valid/ready handshake on input and output.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 8 (elaboration error otherwise).
- NIBBLES, WIDTH/4, derived; number of add cycles. Not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry into bit 0.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, registered.
- cout  output  1  carry out of bit WIDTH-1, registered.
- busy  output  1  high in RUN or DONE.

Behaviour:
- States: IDLE, RUN, DONE. Counter cnt is clog2(NIBBLES) bits.
- Reset (rst high at a clk edge, any state):
  - state=IDLE, cnt=0, out_valid=0, sum=0, cout=0, carry register=0.
  - Operand shift registers cleared.
  - in_ready=0 while rst is high.
  - An operation in flight is discarded; no partial result is ever presented.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch a and b into shift registers, carry register=cin, cnt=0, go to RUN.
- RUN:
  - in_ready=0; in_valid is ignored.
  - Each cycle the slice adds a_sh[3:0], b_sh[3:0] and the carry register.
  - The slice's sum nibble shifts into sum from the top (sum is right-shifted by 4). Slice carry-out goes to the carry register. a_sh and b_sh right-shift by 4. cnt increments.
  - When cnt==NIBBLES-1 this is the final add: cout is loaded with the slice carry-out, then go to DONE.
- DONE:
  - out_valid=1; sum and cout are held stable.
  - On out_ready: out_valid falls on the next edge and the block returns to IDLE.
  - in_ready stays 0 in DONE; there is no overlap.
- Latency: acceptance edge T; out_valid rises after edge T+NIBBLES.
  - Minimum issue interval is NIBBLES+2 cycles (accept, NIBBLES adds, one DONE cycle).
- Arithmetic: result = (a + b + cin) mod 2^WIDTH, with cout = bit WIDTH of the full sum.
  - No sign handling except under the optional feature.
- sum contents while RUN are intermediate and not meaningful; consumers must only sample sum and cout when out_valid=1.
- busy = (state != IDLE).
- out_ready asserted in IDLE or RUN has no effect.
- Simultaneous rst with in_valid or out_ready: rst wins.

Optional Feature:
- Macro: NIBBLE_SERIAL_ADDER_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit, registered, reset 0): two's-complement overflow, computed as carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - The slice exposes its internal bit-2-to-bit-3 carry. ovf is captured on the final RUN cycle and held in DONE with sum.
- When undefined: port ovf and its logic are absent. All other behaviour is identical.

Decomposition:
- Package nibble_serial_adder_pkg:
  - localparam NIBBLE_W=4.
  - State enum typedef (IDLE, RUN, DONE).
  - Function computing the counter width from WIDTH.
- One sub-module: nibble_add_slice.
  - Combinational: 4-bit a and b plus carry-in give a 4-bit sum, carry-out, and the bit-3 carry-in (used only by the optional feature).
  - Gate-level ripple-carry, consistent with existing combinational adder blocks.

Test Plan:
- WIDTH=16; a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0; out_valid rises exactly 4 cycles after the acceptance edge.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1; carry propagates across all four nibble cycles.
- a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1. Also a=0x0000, b=0x0000, cin=0 -> sum=0x0000, cout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE.
  - out_valid stays 1; sum and cout stay stable; in_ready stays 0.
  - A new in_valid with different operands is ignored.
  - Releasing out_ready returns the block to IDLE after one edge.
- Assert rst for one cycle during the 2nd RUN cycle -> next cycle state=IDLE, out_valid=0, sum=0, busy=0. A following op 0x00FF+0x0F01 yields sum=0x1000, cout=0.
- With NIBBLE_SERIAL_ADDER_OVF_EN:
  - 0x7FFF+0x0001 -> sum=0x8000, ovf=1, cout=0.
  - 0x8000+0x8000 -> sum=0x0000, ovf=1, cout=1.
  - 0x1234+0x4321 -> ovf=0.
